// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, S-box, Rcon, GF(2^8) helpers,
// key-length derivations and byte/word extraction helpers.
// Byte k of a 128-bit block lives in bits [127-8k -: 8] (FIPS-197 order).
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_READY,
    ST_RUN,
    ST_DONE
  } aes_state_e;

  localparam int unsigned BLOCK_BITS = 128;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constants, valid for indices 1..10.
  function automatic logic [7:0] rcon(input logic [5:0] idx);
    logic [7:0] r;
    case (idx)
      6'd1:    r = 8'h01;
      6'd2:    r = 8'h02;
      6'd3:    r = 8'h04;
      6'd4:    r = 8'h08;
      6'd5:    r = 8'h10;
      6'd6:    r = 8'h20;
      6'd7:    r = 8'h40;
      6'd8:    r = 8'h80;
      6'd9:    r = 8'h1b;
      6'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic int unsigned calc_nk(input int unsigned key_bits);
    return key_bits / 32;
  endfunction

  function automatic int unsigned calc_nr(input int unsigned nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] idx);
    return s[{~idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] s, input logic [1:0] idx);
    return s[{~idx, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round.
//   i_state     : 128-bit state entering the round
//   i_round_key : round key for this round
//   i_last      : final round, MixColumns skipped
//   o_state     : SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_last,
  output logic [127:0] o_state
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    sb = '{default: '0};
    sr = '{default: '0};
    mc = '{default: '0};
    o_state = '0;

    for (int unsigned k = 0; k < 16; k++) begin
      sb[k] = sbox(get_byte(i_state, 4'(k)));
    end

    // Column-major: byte 4c+r is row r, column c; row r rotates left by r.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end

    for (int unsigned c = 0; c < 4; c++) begin
      mc[4*c]   = gmul2(sr[4*c]) ^ gmul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ gmul2(sr[4*c+1]) ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
      mc[4*c+3] = gmul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
    end

    for (int unsigned k = 0; k < 16; k++) begin
      o_state[{~4'(k), 3'b000} +: 8] = (i_last ? sr[k] : mc[k]) ^ get_byte(i_round_key, 4'(k));
    end
  end

endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES-128/192/256 encryption core, one round per clock.
//   i_clock / i_reset       : rising-edge clock, synchronous active-high reset
//   i_key, i_key_valid      : key load request; o_key_ready acknowledges
//   i_plain, i_valid        : plaintext input; o_ready acknowledges
//   o_cipher, o_valid       : ciphertext output, held until i_ready
// The key is expanded one word per clock into a round-key store before any
// plaintext is accepted.
module aes_enc_core
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [0:KEY_BITS-1] i_key,
  input  logic                i_key_valid,
  output logic                o_key_ready,
  input  logic [0:127]        i_plain,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [0:127]        o_cipher,
  output logic                o_valid,
  input  logic                i_ready
);

  localparam int unsigned NK   = calc_nk(KEY_BITS);
  localparam int unsigned NR   = calc_nr(NK);
  localparam int unsigned NW   = 4 * (NR + 1);
  localparam logic [5:0]  NK6   = 6'(NK);
  localparam logic [5:0]  LAST6 = 6'(NW - 1);
  localparam logic [3:0]  NR4   = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_enc_core: KEY_BITS must be 128, 192 or 256");
  end

  aes_state_e   state_q, state_d;
  logic [31:0]  w_q [NW];
  logic [31:0]  w_d [NW];
  logic [5:0]   widx_q, widx_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] st_q, st_d;
  logic [127:0] cipher_q, cipher_d;
  logic         valid_q, valid_d;

  logic [127:0] rk0;
  logic [127:0] rk_sel;
  logic [127:0] round_out;
  logic         last_round;
  logic [31:0]  prev_word;
  logic [31:0]  f_word;
  logic [31:0]  new_word;
  logic         pt_ready;
  logic         pt_acc;
  logic         key_ready;
  logic         key_acc;

  always_comb begin
    rk0        = {w_q[0], w_q[1], w_q[2], w_q[3]};
    rk_sel     = {w_q[{round_q, 2'b00}], w_q[{round_q, 2'b01}],
                  w_q[{round_q, 2'b10}], w_q[{round_q, 2'b11}]};
    last_round = (round_q == NR4);
  end

  aes_round u_round (
    .i_state     (st_q),
    .i_round_key (rk_sel),
    .i_last      (last_round),
    .o_state     (round_out)
  );

  // Next expanded word w[widx_q].
  always_comb begin
    prev_word = w_q[widx_q - 6'd1];
    f_word    = prev_word;
    if ((widx_q % NK6) == 6'd0) begin
      f_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon(widx_q / NK6), 24'h000000};
    end else if (NK == 8 && widx_q[2:0] == 3'd4) begin
      f_word = sub_word(prev_word);
    end
    new_word = w_q[widx_q - NK6] ^ f_word;
  end

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    widx_d   = widx_q;
    round_d  = round_q;
    st_d     = st_q;
    cipher_d = cipher_q;
    valid_d  = valid_q;

    // A key reload from DONE can reach READY while the previous block is
    // still unconsumed, so READY alone does not imply room for a new block.
    pt_ready  = (state_q == ST_READY) && !valid_q;
    pt_acc    = pt_ready && i_valid;
    key_ready = ((state_q == ST_IDLE) || (state_q == ST_READY) || (state_q == ST_DONE)) && !pt_acc;
    key_acc   = key_ready && i_key_valid;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: ;
      ST_EXPAND: begin
        w_d[widx_q] = new_word;
        if (widx_q == LAST6) begin
          state_d = ST_READY;
        end else begin
          widx_d = widx_q + 6'd1;
        end
      end
      ST_READY: begin
        if (pt_acc) begin
          st_d    = i_plain ^ rk0;
          round_d = 4'd1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_round) begin
          cipher_d = round_out;
          valid_d  = 1'b1;
          round_d  = '0;
          state_d  = ST_DONE;
        end else begin
          st_d    = round_out;
          round_d = round_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Key load overrides the per-state transition; key_ready already
    // excludes EXPAND, RUN and a same-cycle plaintext accept.
    if (key_acc) begin
      for (int unsigned j = 0; j < NK; j++) begin
        w_d[6'(j)] = i_key[32*j +: 32];
      end
      widx_d  = NK6;
      state_d = ST_EXPAND;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      widx_q   <= '0;
      round_q  <= '0;
      st_q     <= '0;
      cipher_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      round_q  <= round_d;
      st_q     <= st_d;
      cipher_q <= cipher_d;
      valid_q  <= valid_d;
    end
  end

  // Key store contents are only meaningful once the FSM leaves IDLE.
  always_ff @(posedge i_clock) begin
    w_q <= w_d;
  end

  always_comb begin
    o_key_ready = key_ready;
    o_ready     = pt_ready;
    o_cipher    = cipher_q;
    o_valid     = valid_q;
  end

endmodule

// File: tb/tb_aes_enc_core.sv
module tb_aes_enc_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: AES-128
  logic [0:127] key_a;
  logic         kv_a, kr_a, v_a, or_a, ov_a, ir_a;
  logic [0:127] p_a, c_a;
  // Instance B: AES-192
  logic [0:191] key_b;
  logic         kv_b, kr_b, v_b, or_b, ov_b, ir_b;
  logic [0:127] p_b, c_b;
  // Instance C: AES-256
  logic [0:255] key_c;
  logic         kv_c, kr_c, v_c, or_c, ov_c, ir_c;
  logic [0:127] p_c, c_c;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K128_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_A   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_A   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K128_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_B   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] K192   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_enc_core #(.KEY_BITS(128)) u_dut_128 (
    .i_clock(clk), .i_reset(rst), .i_key(key_a), .i_key_valid(kv_a), .o_key_ready(kr_a),
    .i_plain(p_a), .i_valid(v_a), .o_ready(or_a), .o_cipher(c_a), .o_valid(ov_a), .i_ready(ir_a)
  );

  aes_enc_core #(.KEY_BITS(192)) u_dut_192 (
    .i_clock(clk), .i_reset(rst), .i_key(key_b), .i_key_valid(kv_b), .o_key_ready(kr_b),
    .i_plain(p_b), .i_valid(v_b), .o_ready(or_b), .o_cipher(c_b), .o_valid(ov_b), .i_ready(ir_b)
  );

  aes_enc_core #(.KEY_BITS(256)) u_dut_256 (
    .i_clock(clk), .i_reset(rst), .i_key(key_c), .i_key_valid(kv_c), .o_key_ready(kr_c),
    .i_plain(p_c), .i_valid(v_c), .o_ready(or_c), .o_cipher(c_c), .o_valid(ov_c), .i_ready(ir_c)
  );

  // Drive helpers for instance A (no checking inside). Called just after a negedge.
  task automatic load_key_a(input logic [127:0] k, output int edges);
    key_a = k;
    kv_a  = 1'b1;
    @(negedge clk);
    kv_a  = 1'b0;
    edges = 0;
    while (!kr_a && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic enc_a(input logic [127:0] pt, output int cyc);
    p_a = pt;
    v_a = 1'b1;
    @(negedge clk);
    v_a = 1'b0;
    cyc = 0;
    while (!ov_a && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b want 0", ov_a); end
    checks++; if (or_a !== 1'b0) begin errors++; $display("FAIL reset_o_ready got %b want 0", or_a); end
    checks++; if (kr_a !== 1'b1) begin errors++; $display("FAIL reset_o_key_ready got %b want 1", kr_a); end
    checks++; if (c_a !== 128'h0) begin errors++; $display("FAIL reset_o_cipher got %h want 0", c_a); end
    checks++; if (kr_b !== 1'b1 || kr_c !== 1'b1) begin errors++; $display("FAIL reset_key_ready_192_256 got %b%b want 11", kr_b, kr_c); end
  endtask

  task automatic test_aes128;
    int e, cyc;
    load_key_a(K128_A, e);
    checks++; if (e != 40) begin errors++; $display("FAIL aes128_expand_edges got %0d want 40", e); end
    checks++; if (or_a !== 1'b1) begin errors++; $display("FAIL aes128_ready got %b want 1", or_a); end
    enc_a(PT_A, cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL aes128_latency got %0d want 10", cyc); end
    checks++; if (c_a !== CT_A) begin errors++; $display("FAIL aes128_cipher got %h want %h", c_a, CT_A); end
    checks++; if (or_a !== 1'b0) begin errors++; $display("FAIL aes128_ready_while_valid got %b want 0", or_a); end
    ir_a = 1'b1;
    @(negedge clk);
    ir_a = 1'b0;
    checks++; if (ov_a !== 1'b0 || or_a !== 1'b1) begin errors++; $display("FAIL aes128_consume got valid=%b ready=%b want 0 1", ov_a, or_a); end
  endtask

  task automatic test_simultaneous;
    int e, cyc;
    p_a = PT_A; v_a = 1'b1;
    key_a = K128_B; kv_a = 1'b1;
    #1;
    checks++; if (kr_a !== 1'b0) begin errors++; $display("FAIL simul_key_ready got %b want 0", kr_a); end
    @(negedge clk);
    v_a = 1'b0; kv_a = 1'b0;
    checks++; if (or_a !== 1'b0 || kr_a !== 1'b0) begin errors++; $display("FAIL simul_run_handshake got ready=%b key_ready=%b want 0 0", or_a, kr_a); end
    cyc = 0;
    while (!ov_a && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (cyc != 10) begin errors++; $display("FAIL simul_latency got %0d want 10", cyc); end
    checks++; if (c_a !== CT_A) begin errors++; $display("FAIL simul_old_key_cipher got %h want %h", c_a, CT_A); end
    checks++; if (kr_a !== 1'b1) begin errors++; $display("FAIL done_key_ready got %b want 1", kr_a); end
    key_a = K128_B; kv_a = 1'b1;
    @(negedge clk);
    kv_a = 1'b0;
    checks++; if (kr_a !== 1'b0 || ov_a !== 1'b1 || c_a !== CT_A) begin
      errors++; $display("FAIL done_reload_hold got key_ready=%b valid=%b cipher=%h want 0 1 %h", kr_a, ov_a, c_a, CT_A);
    end
    ir_a = 1'b1;
    @(negedge clk);
    ir_a = 1'b0;
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL expand_consume got valid=%b want 0", ov_a); end
    e = 0;
    while (!kr_a && e < 100) begin @(negedge clk); e++; end
    checks++; if (kr_a !== 1'b1) begin errors++; $display("FAIL reload_expand_timeout got key_ready=%b want 1", kr_a); end
    enc_a(PT_B, cyc);
    checks++; if (c_a !== CT_B) begin errors++; $display("FAIL reload_new_key_cipher got %h want %h", c_a, CT_B); end
    ir_a = 1'b1;
    @(negedge clk);
    ir_a = 1'b0;
  endtask

  task automatic test_backpressure;
    int cyc;
    enc_a(PT_B, cyc);
    checks++; if (cyc != 10 || c_a !== CT_B) begin errors++; $display("FAIL bp_first got cyc=%0d cipher=%h want 10 %h", cyc, c_a, CT_B); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (ov_a !== 1'b1 || c_a !== CT_B) begin
        errors++; $display("FAIL bp_hold cycle %0d got valid=%b cipher=%h want 1 %h", i, ov_a, c_a, CT_B);
      end
      checks++; if (or_a !== 1'b0) begin errors++; $display("FAIL bp_ready cycle %0d got %b want 0", i, or_a); end
    end
    ir_a = 1'b1;
    @(negedge clk);
    ir_a = 1'b0;
    checks++; if (ov_a !== 1'b0 || or_a !== 1'b1) begin errors++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", ov_a, or_a); end
  endtask

  task automatic test_aes192;
    int e, cyc;
    key_b = K192; kv_b = 1'b1;
    @(negedge clk);
    kv_b = 1'b0;
    e = 0;
    while (!kr_b && e < 200) begin @(negedge clk); e++; end
    checks++; if (e != 46) begin errors++; $display("FAIL aes192_expand_edges got %0d want 46", e); end
    p_b = PT_B; v_b = 1'b1;
    @(negedge clk);
    v_b = 1'b0;
    cyc = 0;
    while (!ov_b && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (cyc != 12) begin errors++; $display("FAIL aes192_latency got %0d want 12", cyc); end
    checks++; if (c_b !== CT192) begin errors++; $display("FAIL aes192_cipher got %h want %h", c_b, CT192); end
    ir_b = 1'b1;
    @(negedge clk);
    ir_b = 1'b0;
  endtask

  task automatic test_aes256;
    int e, cyc;
    key_c = K256; kv_c = 1'b1;
    @(negedge clk);
    kv_c = 1'b0;
    e = 0;
    while (!kr_c && e < 200) begin @(negedge clk); e++; end
    checks++; if (e != 52) begin errors++; $display("FAIL aes256_expand_edges got %0d want 52", e); end
    p_c = PT_B; v_c = 1'b1;
    @(negedge clk);
    v_c = 1'b0;
    cyc = 0;
    while (!ov_c && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (cyc != 14) begin errors++; $display("FAIL aes256_latency got %0d want 14", cyc); end
    checks++; if (c_c !== CT256) begin errors++; $display("FAIL aes256_cipher got %h want %h", c_c, CT256); end
    ir_c = 1'b1;
    @(negedge clk);
    ir_c = 1'b0;
  endtask

  task automatic test_reset_abort;
    int e, cyc;
    logic seen;
    // Reset at round 5 of RUN.
    p_a = PT_B; v_a = 1'b1;
    @(negedge clk);
    v_a = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ov_a !== 1'b0 || or_a !== 1'b0 || kr_a !== 1'b1) begin
      errors++; $display("FAIL run_reset got valid=%b ready=%b key_ready=%b want 0 0 1", ov_a, or_a, kr_a);
    end
    seen = 1'b0;
    p_a = PT_B; v_a = 1'b1;
    repeat (20) begin @(negedge clk); if (ov_a || or_a) seen = 1'b1; end
    v_a = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL idle_ignores_valid got activity=%b want 0", seen); end
    // Reset mid-EXPAND.
    key_a = K128_B; kv_a = 1'b1;
    @(negedge clk);
    kv_a = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (kr_a !== 1'b0) begin errors++; $display("FAIL expand_busy got key_ready=%b want 0", kr_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ov_a !== 1'b0 || or_a !== 1'b0 || kr_a !== 1'b1) begin
      errors++; $display("FAIL expand_reset got valid=%b ready=%b key_ready=%b want 0 0 1", ov_a, or_a, kr_a);
    end
    seen = 1'b0;
    v_a = 1'b1;
    repeat (10) begin @(negedge clk); if (ov_a || or_a) seen = 1'b1; end
    v_a = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL post_expand_reset_ignores_valid got activity=%b want 0", seen); end
    load_key_a(K128_A, e);
    checks++; if (e != 40) begin errors++; $display("FAIL recover_expand_edges got %0d want 40", e); end
    enc_a(PT_A, cyc);
    checks++; if (cyc != 10 || c_a !== CT_A) begin errors++; $display("FAIL recover_cipher got cyc=%0d cipher=%h want 10 %h", cyc, c_a, CT_A); end
    ir_a = 1'b1;
    @(negedge clk);
    ir_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    key_a = '0; kv_a = 1'b0; p_a = '0; v_a = 1'b0; ir_a = 1'b0;
    key_b = '0; kv_b = 1'b0; p_b = '0; v_b = 1'b0; ir_b = 1'b0;
    key_c = '0; kv_c = 1'b0; p_c = '0; v_c = 1'b0; ir_c = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_aes128;
    test_simultaneous;
    test_backpressure;
    test_aes192;
    test_aes256;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_enc_core.md
Name: aes_enc_core

Overview:
- Iterative AES encryption engine, parametrised for AES-128/192/256 through KEY_BITS.
- It replaces the fixed-key, single-shot AES-128 top-level flow with a loadable key, an expanded round-key store, and valid/ready handshakes on both the input and output sides.
- One round executes per clock. It sits between the plaintext source and the ciphertext sink in the crypto datapath.

Parameters:
KEY_BITS, 128, key length; legal values are 128, 192 and 256. Any other value is a synthesis-time error.
NK, derived (KEY_BITS/32), key length in 32-bit words: 4, 6 or 8.
NR, derived (NK+6), number of rounds: 10, 12 or 14.

Ports:
i_clock  in  1  sole clock, all logic on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_key  in  KEY_BITS  cipher key [0:KEY_BITS-1]; byte 0 is bits 0..7 (FIPS-197 order).
i_key_valid  in  1  request to load i_key.
o_key_ready  out  1  high in IDLE, READY and DONE; a key load is accepted when i_key_valid and o_key_ready are both high.
i_plain  in  128  plaintext [0:127]; byte 0 is bits 0..7, column-major state.
i_valid  in  1  plaintext valid.
o_ready  out  1  high only in READY.
o_cipher  out  128  ciphertext register, same byte order as i_plain.
o_valid  out  1  ciphertext valid; held until accepted.
i_ready  in  1  sink ready.

Behaviour:
- Reset values: o_cipher=0, o_valid=0, o_ready=0, o_key_ready=1. FSM goes to IDLE, key store is marked invalid, round counter=0. A reset mid-expansion or mid-encryption aborts immediately with no output.
- FSM states: IDLE, EXPAND, READY, RUN, DONE.
- IDLE (no valid key):
  - key accept -> EXPAND.
  - i_valid is ignored.
- Key accept edge:
  - w[0..NK-1] are loaded from i_key; the word index is set to NK.
- EXPAND, one word per edge:
  - w[i] = w[i-NK] ^ f(w[i-1]).
  - f = SubWord(RotWord) ^ Rcon[i/NK] when i mod NK == 0.
  - f = SubWord only when NK==8 and i mod 8 == 4.
  - Otherwise f = identity.
  - The phase lasts 4*(NR+1)-NK edges (40/46/52). After the edge that writes w[4*NR+3], go to READY.
  - o_key_ready=0 and o_ready=0 throughout.
- READY:
  - plaintext accept (i_valid & o_ready): state <= i_plain ^ rk0, round <= 1, go to RUN.
  - key accept: go to EXPAND; the new key overwrites the old one.
  - If i_valid and i_key_valid are both high in the same cycle, the plaintext wins and the key request is not acknowledged. o_key_ready is driven low that cycle.
- RUN, one edge per round r:
  - For r<NR: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[r].
  - At r==NR: MixColumns is omitted, o_cipher <= result, o_valid <= 1, go to DONE.
  - Latency: o_valid rises NR edges after the accept edge (10/12/14).
  - i_key_valid is ignored in RUN.
- DONE:
  - o_cipher and o_valid are held stable while i_ready=0.
  - On i_ready=1: o_valid <= 0, go to READY. o_ready is first high the following cycle; there is no same-cycle back-to-back accept.
  - Key accept in DONE is permitted and goes to EXPAND. The pending output is still held until i_ready, so o_valid stays 1 through EXPAND until it is consumed.
  - o_ready is 0 while o_valid=1.
- Round-key store:
  - 4*(NR+1) x 32-bit register array; rk[r] = w[4r..4r+3].
  - The word index counter is 6 bits wide and does not wrap; it stops at the last word.
  - Rcon is indexed 1..10; AES-256 uses up to Rcon[7].
- S-boxes: 16 for the round datapath plus 4 for the key schedule, combinational.
- There are no combinational paths from inputs to outputs other than o_key_ready's dependency on i_valid in READY.

Decomposition:
- Shared package aes_pkg holds:
  - FSM state encoding;
  - the S-box function / 256-entry constant;
  - Rcon constant array;
  - xtime/gmul2/gmul3 functions;
  - NK/NR derivation functions;
  - byte/word extraction helpers.
- One sub-module, aes_round: combinational, inputs state, round key and i_last. It performs SubBytes, ShiftRows, MixColumns when not last, and AddRoundKey.
- The key schedule stays in aes_enc_core.

Test Plan:
- KEY_BITS=128: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> o_cipher 3925841d02dc09fbdc118597196a0b32. o_key_ready returns 40 edges after key accept; o_valid rises 10 edges after pt accept.
- KEY_BITS=192: key 000102..1617, pt 00112233445566778899aabbccddeeff -> dda97ca4864cdfe06eaf70a0ec0d7191. Expansion takes 46 edges, latency 12.
- KEY_BITS=256: key 000102..1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089. Expansion takes 52 edges, latency 14.
- Backpressure (128): hold i_ready=0 for 20 cycles after o_valid. o_cipher stays at 69c4e0d86a7b0430d8cdb78070b4c55a (key 000102..0f) and o_ready stays 0. After the i_ready pulse, o_valid falls and o_ready rises next cycle.
- Simultaneous i_valid and i_key_valid in READY: the plaintext is encrypted with the old key, and the key is not acknowledged (o_key_ready=0 that cycle). Reloading a new key in DONE yields correct ciphertext for the next block.
- Assert i_reset at round 5 of RUN and again mid-EXPAND. Next cycle: o_valid=0, o_ready=0, o_key_ready=1. i_valid is ignored until a new key is fully expanded.
